// File: rtl/dsram_resp_bridge_if.sv
// -----------------------------------------------------------------------------
// dsram_resp_bridge_if
//   Groups the two sides of the data-SRAM response bridge:
//     - the EX-stage SRAM-style request port (data_sram_*) and the stall back to
//       the pipeline (stallreq_for_mem),
//     - the split-handshake bus (mem_req/mem_addr_ok/mem_data_ok and fields).
//   Modports:
//     slave  : the bridge's view (consumes SRAM requests, drives the bus).
//     master : the environment's view (pipeline + bus slave).
// -----------------------------------------------------------------------------
interface dsram_resp_bridge_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  localparam int STRB_W = DATA_W / 8;

  // SRAM-style request port (EX stage) and load data back to MEM
  logic              data_sram_en;
  logic [STRB_W-1:0] data_sram_wen;
  logic [ADDR_W-1:0] data_sram_addr;
  logic [DATA_W-1:0] data_sram_wdata;
  logic [DATA_W-1:0] data_sram_rdata;
  logic              stallreq_for_mem;

  // Split-handshake bus
  logic              mem_req;
  logic              mem_wr;
  logic [STRB_W-1:0] mem_wstrb;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_addr_ok;
  logic              mem_data_ok;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  data_sram_en, data_sram_wen, data_sram_addr, data_sram_wdata,
    output data_sram_rdata, stallreq_for_mem,
    output mem_req, mem_wr, mem_wstrb, mem_addr, mem_wdata,
    input  mem_addr_ok, mem_data_ok, mem_rdata
  );

  modport master (
    output data_sram_en, data_sram_wen, data_sram_addr, data_sram_wdata,
    input  data_sram_rdata, stallreq_for_mem,
    input  mem_req, mem_wr, mem_wstrb, mem_addr, mem_wdata,
    output mem_addr_ok, mem_data_ok, mem_rdata
  );
endinterface

// File: rtl/dsram_resp_bridge.sv
// -----------------------------------------------------------------------------
// dsram_resp_bridge
//   Turns each synchronous data-SRAM access from EX into one transaction on a
//   split-handshake bus and stalls the pipeline until it completes. Load data is
//   held in a register and presented on data_sram_rdata until the next load
//   completes.
//
// Ports
//   clk        rising-edge clock
//   resetn     asynchronous active-low reset
//   bus        dsram_resp_bridge_if.slave (SRAM request side + bus side)
//   dbg_state  current FSM state (IDLE=0, REQ=1, WAIT=2, DONE=3)
//
// Handshake
//   A bus request is offered while mem_req=1 and is accepted in the cycle where
//   mem_addr_ok=1. The data phase ends in the cycle where mem_data_ok=1 (it may
//   coincide with acceptance). Exactly one transaction is outstanding at a time;
//   data_ok seen when no transaction is waiting for it is ignored.
//
// Configuration
//   DSRAM_WBUF_EN  when defined, adds a one-entry posted write buffer: a store
//                  seen in IDLE is accepted without stalling and drained in the
//                  background; any access arriving while it drains stalls.
// -----------------------------------------------------------------------------
module dsram_resp_bridge #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                 clk,
  input  logic                 resetn,
  dsram_resp_bridge_if.slave   bus,
  output logic [1:0]           dbg_state
);
  localparam int STRB_W = DATA_W / 8;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]        state_q, state_d;
  logic [STRB_W-1:0] wstrb_q, wstrb_d;
  logic [ADDR_W-1:0] addr_q,  addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              resp_done;
  logic              stall_raw;
  logic              is_load;

`ifdef DSRAM_WBUF_EN
  // Set while the in-flight transaction is a posted store (the request
  // registers double as the one-entry write buffer).
  logic              drain_q, drain_d;
`endif

  assign is_load = (bus.data_sram_wen == '0);

  always_comb begin
    state_d   = state_q;
    wstrb_d   = wstrb_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
    resp_done = 1'b0;
`ifdef DSRAM_WBUF_EN
    drain_d   = drain_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (bus.data_sram_en) begin
          wstrb_d = bus.data_sram_wen;
          addr_d  = bus.data_sram_addr;
          wdata_d = bus.data_sram_wdata;
          state_d = S_REQ;
`ifdef DSRAM_WBUF_EN
          drain_d = !is_load;
`endif
        end
      end
      S_REQ: begin
        if (bus.mem_addr_ok) begin
          if (bus.mem_data_ok) resp_done = 1'b1;
          else                 state_d   = S_WAIT;
        end
      end
      S_WAIT: begin
        if (bus.mem_data_ok) resp_done = 1'b1;
      end
      // DONE releases the stall; the requester's still-held en is ignored here.
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (resp_done) begin
      state_d = S_DONE;
      if (wstrb_q == '0) rdata_d = bus.mem_rdata;
`ifdef DSRAM_WBUF_EN
      // A drained posted store has no pipeline waiting on it: skip DONE.
      if (drain_q) state_d = S_IDLE;
      drain_d = 1'b0;
`endif
    end
  end

  // Stall request
  always_comb begin
    stall_raw = 1'b0;
    case (state_q)
`ifdef DSRAM_WBUF_EN
      S_IDLE: stall_raw = bus.data_sram_en & is_load;
      // Draining the buffer only blocks whatever access arrives meanwhile.
      S_REQ,
      S_WAIT: stall_raw = drain_q ? bus.data_sram_en : 1'b1;
`else
      S_IDLE: stall_raw = bus.data_sram_en;
      S_REQ,
      S_WAIT: stall_raw = 1'b1;
`endif
      default: stall_raw = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= S_IDLE;
      wstrb_q <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
`ifdef DSRAM_WBUF_EN
      drain_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      wstrb_q <= wstrb_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
`ifdef DSRAM_WBUF_EN
      drain_q <= drain_d;
`endif
    end
  end

  // Gated by resetn so the stall drops the instant reset asserts, even while
  // the requester still holds en.
  assign bus.stallreq_for_mem = resetn & stall_raw;
  assign bus.data_sram_rdata  = rdata_q;
  assign bus.mem_req          = (state_q == S_REQ);
  assign bus.mem_wr           = (wstrb_q != '0);
  assign bus.mem_wstrb        = wstrb_q;
  assign bus.mem_addr         = addr_q;
  assign bus.mem_wdata        = wdata_q;
  assign dbg_state            = state_q;

endmodule

// File: tb/tb_dsram_resp_bridge.sv
// -----------------------------------------------------------------------------
// tb_dsram_resp_bridge
//   Directed bench for dsram_resp_bridge: a table of accesses with per-access bus
//   delays and hand-computed stall counts / bus fields / load data, run
//   back-to-back with en held through DONE, plus hand sequences for spurious
//   data_ok, the posted write buffer (when DSRAM_WBUF_EN is defined) and reset
//   asserted mid-transaction.
// -----------------------------------------------------------------------------
module tb_dsram_resp_bridge;
  logic       clk;
  logic       resetn;
  logic [1:0] dbg_state;

  dsram_resp_bridge_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  dsram_resp_bridge #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk       (clk),
    .resetn    (resetn),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic [3:0]  wen;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] brd;        // data the bus returns on data_ok
    int          a_dly;      // REQ cycles until addr_ok (>=1)
    int          d_dly;      // WAIT cycles until data_ok (0 = with addr_ok)
    int          exp_stall;  // stalled cycles
    int          exp_req;    // cycles with mem_req=1
    logic [31:0] exp_rdata;  // data_sram_rdata in DONE and after
  } vec_t;

  vec_t vec[8];
  int   nv;

  // ---------------- driver: one access, acting as the bus slave -------------
  task automatic run_txn(input vec_t v, output int stall_n, output int req_n,
                         output int issue_n, output logic [31:0] s_addr,
                         output logic [31:0] s_wdata, output logic [3:0] s_wstrb,
                         output logic s_wr, output logic timeout);
    int   phase;
    int   a_cnt;
    int   d_cnt;
    logic prev_req;
    stall_n = 0; req_n = 0; issue_n = 0; timeout = 1'b1;
    s_addr = '0; s_wdata = '0; s_wstrb = '0; s_wr = 1'b0;
    phase = 0; a_cnt = 0; d_cnt = 0; prev_req = 1'b0;
    @(negedge clk);
    bus.data_sram_en    = 1'b1;
    bus.data_sram_wen   = v.wen;
    bus.data_sram_addr  = v.addr;
    bus.data_sram_wdata = v.wdata;
    for (int c = 0; c < 60; c++) begin
      #1;
      bus.mem_addr_ok = 1'b0;
      bus.mem_data_ok = 1'b0;
      bus.mem_rdata   = 32'h0BAD_F00D;
      if (c > 0 && !bus.stallreq_for_mem) begin
        timeout = 1'b0;
        break;
      end
      if (bus.stallreq_for_mem) stall_n++;
      if (bus.mem_req) begin
        req_n++;
        if (!prev_req) begin
          issue_n++;
          s_addr = bus.mem_addr; s_wdata = bus.mem_wdata;
          s_wstrb = bus.mem_wstrb; s_wr = bus.mem_wr;
        end
      end
      prev_req = bus.mem_req;
      if (phase == 0 && bus.mem_req) begin
        a_cnt++;
        if (a_cnt == v.a_dly) begin
          bus.mem_addr_ok = 1'b1;
          if (v.d_dly == 0) begin
            bus.mem_data_ok = 1'b1; bus.mem_rdata = v.brd; phase = 2;
          end else begin
            phase = 1;
          end
        end
      end else if (phase == 1) begin
        d_cnt++;
        if (d_cnt == v.d_dly) begin
          bus.mem_data_ok = 1'b1; bus.mem_rdata = v.brd; phase = 2;
        end
      end
      @(negedge clk);
    end
  endtask

  // ---------------- main ----------------
  initial begin
    int          stall_n, req_n, issue_n;
    logic [31:0] s_addr, s_wdata;
    logic [3:0]  s_wstrb;
    logic        s_wr, tmo;
    logic [31:0] last_rdata;

    resetn = 1'b0;
    bus.data_sram_en = 1'b0; bus.data_sram_wen = '0;
    bus.data_sram_addr = '0; bus.data_sram_wdata = '0;
    bus.mem_addr_ok = 1'b0; bus.mem_data_ok = 1'b0; bus.mem_rdata = '0;

    // Reset values
    #1;
    check("rst mem_req",   {31'd0, bus.mem_req},          32'd0);
    check("rst stall",     {31'd0, bus.stallreq_for_mem}, 32'd0);
    check("rst mem_wr",    {31'd0, bus.mem_wr},           32'd0);
    check("rst mem_wstrb", {28'd0, bus.mem_wstrb},        32'd0);
    check("rst mem_addr",  bus.mem_addr,                  32'd0);
    check("rst mem_wdata", bus.mem_wdata,                 32'd0);
    check("rst rdata",     bus.data_sram_rdata,           32'd0);
    check("rst state",     {30'd0, dbg_state},            32'd0);
    repeat (2) @(negedge clk);
    resetn = 1'b1;

    // Access table. Store rows exist only in the blocking build; with the
    // write buffer stores do not stall and are covered by their own sequence.
    nv = 0;
    vec[nv++] = '{4'b0000, 32'h0000_0100, 32'h0000_0000, 32'hDEAD_BEEF, 1, 0, 2, 1, 32'hDEAD_BEEF};
    vec[nv++] = '{4'b0000, 32'h0000_0108, 32'h0000_1111, 32'hCAFE_F00D, 2, 3, 6, 2, 32'hCAFE_F00D};
`ifndef DSRAM_WBUF_EN
    vec[nv++] = '{4'b0011, 32'h0000_0204, 32'h0000_ABCD, 32'h5555_5555, 1, 1, 3, 1, 32'hCAFE_F00D};
`endif
    vec[nv++] = '{4'b0000, 32'h0000_03FC, 32'h0000_2222, 32'h1357_9BDF, 3, 0, 4, 3, 32'h1357_9BDF};
`ifndef DSRAM_WBUF_EN
    vec[nv++] = '{4'b1111, 32'h0000_0010, 32'hA5A5_A5A5, 32'h6666_6666, 1, 0, 2, 1, 32'h1357_9BDF};
`endif
    vec[nv++] = '{4'b0000, 32'h0000_0020, 32'h0000_3333, 32'h2468_ACE0, 1, 2, 4, 1, 32'h2468_ACE0};

    // Rows run back-to-back: en stays high through each DONE and the next row's
    // values appear in the following cycle.
    for (int i = 0; i < nv; i++) begin
      run_txn(vec[i], stall_n, req_n, issue_n, s_addr, s_wdata, s_wstrb, s_wr, tmo);
      check($sformatf("row%0d timeout", i), {31'd0, tmo}, 32'd0);
      check($sformatf("row%0d stall cycles", i), stall_n, vec[i].exp_stall);
      check($sformatf("row%0d req cycles", i), req_n, vec[i].exp_req);
      check($sformatf("row%0d issues", i), issue_n, 32'd1);
      check($sformatf("row%0d mem_addr", i), s_addr, vec[i].addr);
      check($sformatf("row%0d mem_wdata", i), s_wdata, vec[i].wdata);
      check($sformatf("row%0d mem_wstrb", i), {28'd0, s_wstrb}, {28'd0, vec[i].wen});
      check($sformatf("row%0d mem_wr", i), {31'd0, s_wr}, {31'd0, (vec[i].wen != 4'b0000)});
      check($sformatf("row%0d rdata", i), bus.data_sram_rdata, vec[i].exp_rdata);
    end
    last_rdata = vec[nv-1].exp_rdata;

    // Held en in DONE must not reissue; rdata holds while idle.
    @(negedge clk);
    bus.data_sram_en = 1'b0;
    #1;
    check("post-done no req", {31'd0, bus.mem_req}, 32'd0);
    check("post-done state", {30'd0, dbg_state}, 32'd0);

    // Spurious data_ok while idle is ignored.
    bus.mem_data_ok = 1'b1;
    bus.mem_rdata   = 32'h1234_5678;
    @(negedge clk);
    bus.mem_data_ok = 1'b0;
    bus.mem_rdata   = 32'h0BAD_F00D;
    #1;
    check("spurious data_ok rdata", bus.data_sram_rdata, last_rdata);
    check("spurious data_ok state", {30'd0, dbg_state}, 32'd0);
    check("spurious data_ok stall", {31'd0, bus.stallreq_for_mem}, 32'd0);

`ifdef DSRAM_WBUF_EN
    // Posted store followed by a load; store data_ok arrives 4 cycles late.
    @(negedge clk);
    bus.data_sram_en = 1'b1; bus.data_sram_wen = 4'b1111;
    bus.data_sram_addr = 32'h0000_0600; bus.data_sram_wdata = 32'h1122_3344;
    #1;
    check("wb store no stall", {31'd0, bus.stallreq_for_mem}, 32'd0);
    @(negedge clk);
    bus.data_sram_wen = 4'b0000; bus.data_sram_addr = 32'h0000_0640;
    bus.data_sram_wdata = 32'h0;
    #1;
    check("wb drain req", {31'd0, bus.mem_req}, 32'd1);
    check("wb drain wr", {31'd0, bus.mem_wr}, 32'd1);
    check("wb drain addr", bus.mem_addr, 32'h0000_0600);
    check("wb drain wdata", bus.mem_wdata, 32'h1122_3344);
    check("wb load stalls in req", {31'd0, bus.stallreq_for_mem}, 32'd1);
    bus.mem_addr_ok = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      bus.mem_addr_ok = 1'b0; bus.mem_data_ok = 1'b0;
      #1;
      check($sformatf("wb wait%0d stall", k), {31'd0, bus.stallreq_for_mem}, 32'd1);
      check($sformatf("wb wait%0d no req", k), {31'd0, bus.mem_req}, 32'd0);
      if (k == 4) begin
        bus.mem_data_ok = 1'b1; bus.mem_rdata = 32'h7777_7777;
      end
    end
    @(negedge clk);
    bus.mem_data_ok = 1'b0; bus.mem_rdata = 32'h0BAD_F00D;
    #1;
    check("wb load idle stall", {31'd0, bus.stallreq_for_mem}, 32'd1);
    check("wb store no rdata", bus.data_sram_rdata, last_rdata);
    @(negedge clk);
    #1;
    check("wb load req", {31'd0, bus.mem_req}, 32'd1);
    check("wb load wr", {31'd0, bus.mem_wr}, 32'd0);
    check("wb load addr", bus.mem_addr, 32'h0000_0640);
    bus.mem_addr_ok = 1'b1; bus.mem_data_ok = 1'b1; bus.mem_rdata = 32'h89AB_CDEF;
    @(negedge clk);
    bus.mem_addr_ok = 1'b0; bus.mem_data_ok = 1'b0; bus.mem_rdata = 32'h0BAD_F00D;
    #1;
    check("wb load done stall", {31'd0, bus.stallreq_for_mem}, 32'd0);
    check("wb load rdata", bus.data_sram_rdata, 32'h89AB_CDEF);
    @(negedge clk);
    bus.data_sram_en = 1'b0;
`endif

    // Reset asserted while waiting for data_ok.
    @(negedge clk);
    bus.data_sram_en = 1'b1; bus.data_sram_wen = 4'b0000;
    bus.data_sram_addr = 32'h0000_0500;
    @(negedge clk);
    #1;
    check("rstmid req", {31'd0, bus.mem_req}, 32'd1);
    bus.mem_addr_ok = 1'b1;
    @(negedge clk);
    bus.mem_addr_ok = 1'b0;
    #1;
    check("rstmid in wait", {30'd0, dbg_state}, 32'd2);
    resetn = 1'b0;
    #1;
    check("rstmid mem_req", {31'd0, bus.mem_req}, 32'd0);
    check("rstmid stall", {31'd0, bus.stallreq_for_mem}, 32'd0);
    check("rstmid rdata", bus.data_sram_rdata, 32'd0);
    check("rstmid state", {30'd0, dbg_state}, 32'd0);
    bus.data_sram_en = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    #1;
    check("post-rst idle req", {31'd0, bus.mem_req}, 32'd0);
    check("post-rst idle stall", {31'd0, bus.stallreq_for_mem}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
